// File: rtl/fetch_pkg.sv
// Shared widths and the fetch queue entry type for the fetch stage.
// Imported by fetch_queue and fetch_unit.
package fetch_pkg;

  localparam int XLEN = 32;
  localparam int ILEN = 32;
  localparam logic [XLEN-1:0] PC_STEP = 32'd4;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO of {pc, instr} entries between imem and decode.
// Power-of-two depth, so the pointers wrap on their own.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int QDEPTH = 2,
  parameter int CW     = $clog2(QDEPTH) + 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  input  logic         flush,
  output logic [CW-1:0] count,
  output fetch_entry_t head
);

  localparam int AW = $clog2(QDEPTH);

  fetch_entry_t    mem [QDEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;

  assign head = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < QDEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, imem request/response tracking, redirect.
// Optional perf counters are built only when FETCH_PERF_EN is defined.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int              QDEPTH   = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [ILEN-1:0] imem_rdata,
  output logic            instr_valid,
  output logic [ILEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc,
  input  logic            instr_ready,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]     perf_fetched,
  output logic [31:0]     perf_stall
`endif
);

  localparam int CW = $clog2(QDEPTH) + 2;

  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] rsp_pc;
  logic [CW-1:0]   live_out;
  logic [CW-1:0]   drop_cnt;
  logic [CW-1:0]   count;
  logic            run;

  logic            fire;
  logic            rsp_kill;
  logic            rsp_live;
  logic            rsp_seen;
  logic            push;
  logic            pop;
  logic [XLEN-1:0] new_pc;
  fetch_entry_t    push_data;
  fetch_entry_t    head;
  logic            unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^redirect_pc[1:0];
  assign new_pc = {redirect_pc[XLEN-1:2], 2'b00};

  // Credit check: queue slots must cover every live response.
  assign imem_req  = run && !redirect_valid
                   && ((count + live_out) < CW'(QDEPTH));
  assign imem_addr = pc;
  assign fire      = imem_req && imem_gnt;

  assign rsp_kill = imem_rvalid && (drop_cnt != '0);
  assign rsp_live = imem_rvalid && (drop_cnt == '0)
                  && (live_out != '0);
  assign rsp_seen = rsp_kill || rsp_live;

  assign push = rsp_live && !redirect_valid;
  assign pop  = instr_valid && instr_ready && !redirect_valid;

  assign push_data.pc    = rsp_pc;
  assign push_data.instr = imem_rdata;

  fetch_queue #(
    .QDEPTH(QDEPTH),
    .CW    (CW)
  ) u_queue (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .push_data(push_data),
    .pop      (pop),
    .flush    (redirect_valid),
    .count    (count),
    .head     (head)
  );

  assign instr_valid = (count != '0);
  assign instr       = head.instr;
  assign instr_pc    = head.pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run      <= 1'b0;
      pc       <= RESET_PC;
      rsp_pc   <= RESET_PC;
      live_out <= '0;
      drop_cnt <= '0;
    end else begin
      run <= 1'b1;
      if (redirect_valid) begin
        pc       <= new_pc;
        rsp_pc   <= new_pc;
        drop_cnt <= drop_cnt + live_out - CW'(rsp_seen);
        live_out <= '0;
      end else begin
        if (fire) begin
          pc <= pc + PC_STEP;
        end
        if (push) begin
          rsp_pc <= rsp_pc + PC_STEP;
        end
        live_out <= live_out + CW'(fire) - CW'(push);
        drop_cnt <= drop_cnt - CW'(rsp_kill);
      end
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched <= '0;
      perf_stall   <= '0;
    end else begin
      perf_fetched <= perf_fetched + 32'(pop);
      perf_stall   <= perf_stall + 32'(run && !instr_valid);
    end
  end
`endif

endmodule
